// File: rtl/led_display_rx.sv
// Receiver for a HUB75-style LED panel bus: synchronises the panel strobes into clk_in,
// deserialises each row and presents it on a valid/ready handshake.
module led_display_rx #(
    parameter int NUM_COLS    = 64,
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk_in,
    input  logic                    n_reset_in,
    input  logic                    bit_clk_in,
    input  logic                    latch_enable_in,
    input  logic                    output_enable_in,
    input  logic [ADDR_W-1:0]       addr_in,
    input  logic [2:0]              rgb_top_in,
    input  logic [2:0]              rgb_bot_in,
    output logic                    row_valid_out,
    input  logic                    row_ready_in,
    output logic [ADDR_W-1:0]       row_addr_out,
    output logic [3*NUM_COLS-1:0]   row_top_out,
    output logic [3*NUM_COLS-1:0]   row_bot_out,
    output logic                    row_err_out,
    output logic                    overflow_out,
    output logic                    display_on_out
);

    localparam int SYNC_W = 3 + ADDR_W + 6;
    localparam int ROW_W  = 3 * NUM_COLS;
    localparam int CNT_W  = $clog2(2 * NUM_COLS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_COLS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(2 * NUM_COLS);

    typedef enum logic {CAP_IDLE  = 1'b0, CAP_SHIFT = 1'b1} cap_state_t;
    typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL  = 1'b1} out_state_t;

    // Output-enable is inverted before synchronising so that a cleared chain reads "display off".
    logic [SYNC_W-1:0] sync_raw;
    logic [SYNC_W-1:0] sync_q [SYNC_STAGES];

    assign sync_raw = {bit_clk_in, latch_enable_in, ~output_enable_in, addr_in, rgb_top_in, rgb_bot_in};

    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            always_ff @(posedge clk_in or negedge n_reset_in) begin
                if (!n_reset_in) sync_q[gi] <= '0;
                else             sync_q[gi] <= sync_raw;
            end
        end else begin : g_rest
            always_ff @(posedge clk_in or negedge n_reset_in) begin
                if (!n_reset_in) sync_q[gi] <= '0;
                else             sync_q[gi] <= sync_q[gi-1];
            end
        end
    end

    logic              s_bclk, s_le, s_on;
    logic [ADDR_W-1:0] s_addr;
    logic [2:0]        s_top, s_bot;

    assign s_bclk = sync_q[SYNC_STAGES-1][SYNC_W-1];
    assign s_le   = sync_q[SYNC_STAGES-1][SYNC_W-2];
    assign s_on   = sync_q[SYNC_STAGES-1][SYNC_W-3];
    assign s_addr = sync_q[SYNC_STAGES-1][SYNC_W-4 -: ADDR_W];
    assign s_top  = sync_q[SYNC_STAGES-1][5:3];
    assign s_bot  = sync_q[SYNC_STAGES-1][2:0];

    assign display_on_out = s_on;

    // Edge detection is registered together with the data so strobes and pixels stay aligned.
    logic              bclk_prev_q, le_prev_q;
    logic              bclk_edge_q, le_edge_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        pix_top_q, pix_bot_q;

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            bclk_prev_q <= 1'b0;
            le_prev_q   <= 1'b0;
            bclk_edge_q <= 1'b0;
            le_edge_q   <= 1'b0;
            addr_q      <= '0;
            pix_top_q   <= '0;
            pix_bot_q   <= '0;
        end else begin
            bclk_prev_q <= s_bclk;
            le_prev_q   <= s_le;
            bclk_edge_q <= s_bclk & ~bclk_prev_q;
            le_edge_q   <= s_le & ~le_prev_q;
            addr_q      <= s_addr;
            pix_top_q   <= s_top;
            pix_bot_q   <= s_bot;
        end
    end

    cap_state_t       cap_state_q, cap_state_d;
    logic [ROW_W-1:0] top_sr_q, top_sr_d, bot_sr_q, bot_sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             capture, cap_err;

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            cap_state_q <= CAP_IDLE;
            top_sr_q    <= '0;
            bot_sr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            cap_state_q <= cap_state_d;
            top_sr_q    <= top_sr_d;
            bot_sr_q    <= bot_sr_d;
            cnt_q       <= cnt_d;
        end
    end

    // A shift in the capture cycle is applied first, so the snapshot uses the _d values.
    always_comb begin
        cap_state_d = cap_state_q;
        top_sr_d    = top_sr_q;
        bot_sr_d    = bot_sr_q;
        cnt_d       = cnt_q;
        capture     = 1'b0;
        cap_err     = 1'b0;
        if (bclk_edge_q) begin
            top_sr_d = {pix_top_q, top_sr_q[ROW_W-1:3]};
            bot_sr_d = {pix_bot_q, bot_sr_q[ROW_W-1:3]};
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        end
        case (cap_state_q)
            CAP_IDLE:  if (bclk_edge_q) cap_state_d = CAP_SHIFT;
            CAP_SHIFT: cap_state_d = CAP_SHIFT;
            default:   cap_state_d = CAP_IDLE;
        endcase
        if (le_edge_q) begin
            capture     = 1'b1;
            cap_err     = (cnt_d != CNT_FULL);
            cnt_d       = '0;
            cap_state_d = CAP_IDLE;
        end
    end

    out_state_t        out_state_q, out_state_d;
    logic [ROW_W-1:0]  row_top_q, row_top_d, row_bot_q, row_bot_d;
    logic [ADDR_W-1:0] row_addr_q, row_addr_d;
    logic              row_err_q, row_err_d;
    logic              ovf_q, ovf_d;
    logic              xfer, load;

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            out_state_q <= OUT_EMPTY;
            row_top_q   <= '0;
            row_bot_q   <= '0;
            row_addr_q  <= '0;
            row_err_q   <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            out_state_q <= out_state_d;
            row_top_q   <= row_top_d;
            row_bot_q   <= row_bot_d;
            row_addr_q  <= row_addr_d;
            row_err_q   <= row_err_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        out_state_d = out_state_q;
        ovf_d       = ovf_q;
        load        = 1'b0;
        xfer        = (out_state_q == OUT_FULL) && row_ready_in;
        case (out_state_q)
            OUT_EMPTY: begin
                if (capture) begin
                    load        = 1'b1;
                    out_state_d = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (capture && xfer)  load = 1'b1;
                else if (capture)     ovf_d = 1'b1;
                else if (xfer)        out_state_d = OUT_EMPTY;
            end
            default: out_state_d = OUT_EMPTY;
        endcase
        row_top_d  = load ? top_sr_d : row_top_q;
        row_bot_d  = load ? bot_sr_d : row_bot_q;
        row_addr_d = load ? addr_q   : row_addr_q;
        row_err_d  = load ? cap_err  : row_err_q;
    end

    assign row_valid_out = (out_state_q == OUT_FULL);
    assign row_addr_out  = row_addr_q;
    assign row_top_out   = row_top_q;
    assign row_bot_out   = row_bot_q;
    assign row_err_out   = row_err_q;
    assign overflow_out  = ovf_q;

endmodule

// File: tb/tb_led_display_rx.sv
// Scoreboard bench for led_display_rx: drives panel rows with slow strobes and checks every
// delivered row against a behavioural model of the panel shift registers.
module tb_led_display_rx;

    localparam int NC  = 64;
    localparam int AW  = 3;
    localparam int SS  = 2;
    localparam int RW  = 3 * NC;

    logic          clk_in = 1'b0;
    logic          n_reset_in = 1'b0;
    logic          bit_clk_in = 1'b0;
    logic          latch_enable_in = 1'b0;
    logic          output_enable_in = 1'b1;
    logic [AW-1:0] addr_in = '0;
    logic [2:0]    rgb_top_in = '0;
    logic [2:0]    rgb_bot_in = '0;
    logic          row_ready_in = 1'b1;
    logic          row_valid_out;
    logic [AW-1:0] row_addr_out;
    logic [RW-1:0] row_top_out, row_bot_out;
    logic          row_err_out, overflow_out, display_on_out;

    led_display_rx #(.NUM_COLS(NC), .ADDR_W(AW), .SYNC_STAGES(SS)) dut (
        .clk_in           (clk_in),
        .n_reset_in       (n_reset_in),
        .bit_clk_in       (bit_clk_in),
        .latch_enable_in  (latch_enable_in),
        .output_enable_in (output_enable_in),
        .addr_in          (addr_in),
        .rgb_top_in       (rgb_top_in),
        .rgb_bot_in       (rgb_bot_in),
        .row_valid_out    (row_valid_out),
        .row_ready_in     (row_ready_in),
        .row_addr_out     (row_addr_out),
        .row_top_out      (row_top_out),
        .row_bot_out      (row_bot_out),
        .row_err_out      (row_err_out),
        .overflow_out     (overflow_out),
        .display_on_out   (display_on_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [AW-1:0] addr;
        logic [RW-1:0] top;
        logic [RW-1:0] bot;
        logic          err;
    } row_t;

    row_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_push  = 0;
    int   n_xfer  = 0;

    logic [RW-1:0] m_top = '0;
    logic [RW-1:0] m_bot = '0;
    int            m_cnt = 0;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Model of one bit_clk edge on the panel side.
    function automatic void model_shift(input logic [2:0] t, input logic [2:0] b);
        m_top = {t, m_top[RW-1:3]};
        m_bot = {b, m_bot[RW-1:3]};
        if (m_cnt < 2 * NC) m_cnt++;
    endfunction

    function automatic void model_capture(input logic [AW-1:0] a, input bit push);
        row_t r;
        r.addr = a;
        r.top  = m_top;
        r.bot  = m_bot;
        r.err  = (m_cnt != NC);
        m_cnt  = 0;
        if (push) begin
            exp_q.push_back(r);
            n_push++;
        end
    endfunction

    task automatic send_pixel(input logic [2:0] t, input logic [2:0] b);
        rgb_top_in = t;
        rgb_bot_in = b;
        bit_clk_in = 1'b0;
        tick(2);
        bit_clk_in = 1'b1;
        tick(2);
        model_shift(t, b);
    endtask

    task automatic pulse_le(input logic [AW-1:0] a, input bit push, input bit chk_lat);
        addr_in = a;
        latch_enable_in = 1'b1;
        tick(2);
        latch_enable_in = 1'b0;
        if (chk_lat) begin
            tick(1);
            check_val("latency_early", 256'(row_valid_out), 256'(0));
            tick(1);
            check_val("latency_valid", 256'(row_valid_out), 256'(1));
        end else begin
            tick(2);
        end
        model_capture(a, push);
    endtask

    // mode 0: column c = c mod 8 on top, (3c) mod 8 on bottom; mode 1: random pixels.
    task automatic send_pixels(input int n, input int mode);
        for (int c = 0; c < n; c++) begin
            if (mode == 0) send_pixel(3'(c % 8), 3'((3 * c) % 8));
            else           send_pixel(3'($urandom_range(7)), 3'($urandom_range(7)));
        end
    endtask

    task automatic send_row(input int n, input int mode, input logic [AW-1:0] a, input bit push,
                            input bit chk_lat);
        send_pixels(n, mode);
        pulse_le(a, push, chk_lat);
    endtask

    // Final bit_clk rise and latch rise land in the same synchroniser cycle.
    task automatic send_row_aligned(input logic [AW-1:0] a);
        logic [2:0] t, b;
        send_pixels(NC - 1, 1);
        t = 3'($urandom_range(7));
        b = 3'($urandom_range(7));
        rgb_top_in = t;
        rgb_bot_in = b;
        addr_in = a;
        bit_clk_in = 1'b0;
        latch_enable_in = 1'b0;
        tick(2);
        bit_clk_in = 1'b1;
        latch_enable_in = 1'b1;
        tick(2);
        latch_enable_in = 1'b0;
        tick(2);
        model_shift(t, b);
        model_capture(a, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_valid"}, 256'(row_valid_out), 256'(0));
        check_val({tag, "_addr"},  256'(row_addr_out),  256'(0));
        check_val({tag, "_top"},   256'(row_top_out),   256'(0));
        check_val({tag, "_bot"},   256'(row_bot_out),   256'(0));
        check_val({tag, "_err"},   256'(row_err_out),   256'(0));
        check_val({tag, "_ovf"},   256'(overflow_out),  256'(0));
        check_val({tag, "_on"},    256'(display_on_out), 256'(0));
    endtask

    // Scoreboard: every accepted transfer pops and compares one expected row.
    always @(negedge clk_in) begin
        if (n_reset_in && row_valid_out && row_ready_in) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                check_val("xfer_unexpected", 256'(1), 256'(0));
            end else begin
                row_t r;
                r = exp_q.pop_front();
                $display("[TB] row %0d: addr=%0d err=%0d", n_xfer, row_addr_out, row_err_out);
                check_val("row_addr", 256'(row_addr_out), 256'(r.addr));
                check_val("row_top",  256'(row_top_out),  256'(r.top));
                check_val("row_bot",  256'(row_bot_out),  256'(r.bot));
                check_val("row_err",  256'(row_err_out),  256'(r.err));
            end
        end
    end

    initial begin
        logic [RW-1:0] held_top;
        logic [AW-1:0] held_addr;
        int            wait_cnt;

        tick(3);
        check_all_zero("reset");
        n_reset_in = 1'b1;
        tick(2);

        output_enable_in = 1'b0;
        tick(SS + 1);
        check_val("display_on", 256'(display_on_out), 256'(1));

        // Basic row with latency check, then aligned final shift.
        send_row(NC, 0, 3'd5, 1'b1, 1'b1);
        tick(4);
        send_row_aligned(3'd2);
        tick(4);

        // Short row flagged, full row clean.
        send_row(NC - 1, 1, 3'd3, 1'b1, 1'b0);
        tick(4);
        send_row(NC, 1, 3'd4, 1'b1, 1'b0);
        tick(4);

        // Back-to-back latches with 2-cycle spacing.
        send_row(NC, 1, 3'd6, 1'b1, 1'b0);
        pulse_le(3'd1, 1'b1, 1'b0);
        pulse_le(3'd2, 1'b1, 1'b0);
        pulse_le(3'd3, 1'b1, 1'b0);
        tick(6);
        check_val("b2b_ovf", 256'(overflow_out), 256'(0));

        // Backpressure: second row dropped.
        row_ready_in = 1'b0;
        send_row(NC, 1, 3'd7, 1'b1, 1'b0);
        held_top  = m_top;
        held_addr = 3'd7;
        send_row(NC, 1, 3'd0, 1'b0, 1'b0);
        tick(6);
        check_val("bp_valid", 256'(row_valid_out), 256'(1));
        check_val("bp_ovf",   256'(overflow_out),  256'(1));
        check_val("bp_top",   256'(row_top_out),   256'(held_top));
        check_val("bp_addr",  256'(row_addr_out),  256'(held_addr));
        row_ready_in = 1'b1;
        tick(1);
        tick(1);
        check_val("bp_drained", 256'(row_valid_out), 256'(0));

        // Reset mid-row discards partial data and the sticky flag.
        send_pixels(30, 1);
        bit_clk_in = 1'b0;
        latch_enable_in = 1'b0;
        n_reset_in = 1'b0;
        #1;
        check_all_zero("midreset");
        tick(3);
        n_reset_in = 1'b1;
        m_top = '0;
        m_bot = '0;
        m_cnt = 0;
        tick(4);
        send_row(NC, 0, 3'd5, 1'b1, 1'b0);
        tick(4);
        check_val("post_reset_ovf", 256'(overflow_out), 256'(0));

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 200) begin
            tick(1);
            wait_cnt++;
        end
        check_val("queue_empty", 256'(exp_q.size()), 256'(0));
        check_val("xfer_count",  256'(n_xfer),        256'(n_push));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_display_rx.md
LED_DISPLAY_RX -- requirements
Module: led_display_rx

Interface
REQ-001 Parameter NUM_COLS, default 64: pixels shifted per row per half-panel.
REQ-002 Parameter ADDR_W, default 3: row address width.
REQ-003 Parameter SYNC_STAGES, default 2: synchroniser depth on every panel-side input, minimum 2.
REQ-004 clk_in  input  1  system clock.
REQ-005 n_reset_in  input  1  reset, asynchronous, active-low.
REQ-006 bit_clk_in  input  1  panel shift clock, asynchronous to clk_in.
REQ-007 latch_enable_in  input  1  panel latch strobe, active-high.
REQ-008 output_enable_in  input  1  panel output enable, active-low.
REQ-009 addr_in  input  ADDR_W  panel row address.
REQ-010 rgb_top_in / rgb_bot_in  input  3 each  serial pixel data {R,G,B} for the top and bottom halves.
REQ-011 row_valid_out  output  1  a captured row is presented.
REQ-012 row_ready_in  input  1  consumer accepts the row.
REQ-013 row_addr_out  output  ADDR_W  address of the presented row.
REQ-014 row_top_out / row_bot_out  output  3*NUM_COLS each  presented pixels; bits [3c+2:3c] hold column c.
REQ-015 row_err_out  output  1  the presented row did not have exactly NUM_COLS shifts.
REQ-016 overflow_out  output  1  sticky flag: a row was dropped.
REQ-017 display_on_out  output  1  synchronised NOT output_enable_in.

Function
REQ-018 All panel inputs SHALL pass through SYNC_STAGES flops; data and addr SHALL use the same depth as the strobes, so they stay aligned.
REQ-019 A bit_clk rising edge SHALL be the cycle the synchronised value is 1 while its previous-cycle value was 0; a latch_enable rising edge is detected the same way.
REQ-020 On each bit_clk edge, both 3*NUM_COLS shift registers SHALL shift toward column 0 and load the sampled rgb values into column NUM_COLS-1.
  - Result: the first pixel shifted ends at column 0 after NUM_COLS shifts.
REQ-021 The shift counter SHALL increment per bit_clk edge and saturate at 2*NUM_COLS.
REQ-022 Capture FSM states:
  - IDLE: counter 0. The first bit_clk edge moves it to SHIFT.
  - SHIFT: a latch_enable edge performs a capture and returns to IDLE.
  - A latch_enable edge in IDLE performs a capture with counter 0.
REQ-023 Capture SHALL snapshot the shift registers and the synchronised addr, set err = (counter != NUM_COLS), then clear the counter.
  - The shift registers are not cleared.
REQ-024 If a bit_clk edge and a latch_enable edge occur in the same cycle, the shift SHALL apply first, and the capture SHALL include that shift and that count.
REQ-025 Output stage states:
  - EMPTY: a capture loads the row registers and sets row_valid_out on the next edge.
  - FULL: row_valid_out is held and the row data is stable until row_valid_out and row_ready_in are both high, then the stage returns to EMPTY.
REQ-026 A capture in FULL without a same-cycle transfer SHALL discard the new row, set overflow_out, and leave the presented row unchanged.
REQ-027 A capture in the same cycle as a transfer SHALL load the new row, and row_valid_out SHALL remain 1.
REQ-028 Latency: row_valid_out SHALL rise SYNC_STAGES+1 clk_in cycles after the first clk_in edge that samples latch_enable_in high, provided the output stage is EMPTY.
REQ-029 bit_clk_in and latch_enable_in SHALL be at least 2 clk_in periods high and 2 low; narrower pulses are unsupported and not detected.
REQ-030 display_on_out SHALL be combinationally derived from the last synchroniser stage only.

Reset
REQ-031 While n_reset_in is low, all outputs SHALL be 0.
  - row_* buses, row_err_out and overflow_out are 0; display_on_out is 0.
  - Synchronisers, edge history, shift registers and the counter are 0; both FSMs are in IDLE/EMPTY.
REQ-032 Reset mid-row or mid-handshake SHALL discard all partial and presented data.
  - The first capture after reset behaves as from power-up.

Verification
REQ-033 Shift 64 pixels with column c = c mod 8, addr 5, then pulse LE -> one row: row_addr_out=5, column c = c mod 8, row_err_out=0.
REQ-034 Shift 63 pixels then pulse LE -> row_err_out=1; a following 64-pixel row gives row_err_out=0.
REQ-035 Hold row_ready_in=0 and send two rows -> the first row stays presented and overflow_out=1; release ready -> one transfer, then row_valid_out=0.
REQ-036 Align the final bit_clk edge with the LE edge at the synchroniser output -> the capture includes the 64th pixel and row_err_out=0.
REQ-037 Assert n_reset_in after 30 shifts, release, then send a full row -> correct row; row_err_out=0; overflow_out=0.
REQ-038 Hold ready=1 and send back-to-back rows with 2-cycle LE spacing -> every row is delivered in order and overflow_out stays 0.
